// File: rtl/shared_buffer_alloc_ctrl.sv
// Shared input-buffer allocation controller.
// Keeps the free-slot list as a circular FIFO, round-robin arbitrates one
// slot allocation and one slot release per cycle, and tracks how many slots
// each VC holds so that no VC can hold more than MAX_PER_REQ slots.
//
// Handshakes:
//   alloc: alloc_req_i[i] is a level request. Each accepted request pops one
//          slot at the clock edge; alloc_gnt_o[i] pulses for one cycle on the
//          following cycle with alloc_slot_o carrying the popped index. A VC
//          that keeps its request high is simply granted again later.
//   free:  free_req_i[i]/free_slot_i form a valid pair. free_ack_o[i] is the
//          same-cycle ready: when it is high the slot is pushed at the edge.
//          A refused release is dropped (the VC must retry) and may set a
//          sticky error flag.
module shared_buffer_alloc_ctrl #(
   parameter  int NUM_REQ     = 4,
   parameter  int NUM_SLOTS   = 32,
   parameter  int MAX_PER_REQ = 16,
   localparam int SLOT_W      = $clog2(NUM_SLOTS),
   localparam int CNT_W       = $clog2(NUM_SLOTS + 1),
   localparam int VC_CNT_W    = $clog2(MAX_PER_REQ + 1)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [NUM_REQ-1:0]          alloc_req_i,
   output logic [NUM_REQ-1:0]          alloc_gnt_o,
   output logic [SLOT_W-1:0]           alloc_slot_o,
   input  logic [NUM_REQ-1:0]          free_req_i,
   input  logic [NUM_REQ*SLOT_W-1:0]   free_slot_i,
   output logic [NUM_REQ-1:0]          free_ack_o,
   output logic [CNT_W-1:0]            free_count_o,
   output logic [NUM_REQ*VC_CNT_W-1:0] vc_count_o,
   output logic                        none_free_o,
   output logic                        err_overflow_o,
   output logic                        err_underflow_o
);

   localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Free-list storage and pointers
   logic [SLOT_W-1:0]   fifo_q [NUM_SLOTS];
   logic [SLOT_W-1:0]   head_q, head_d;
   logic [SLOT_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]    free_count_q, free_count_d;

   // Per-VC occupancy
   logic [VC_CNT_W-1:0] vc_cnt_q [NUM_REQ];
   logic [VC_CNT_W-1:0] vc_cnt_d [NUM_REQ];

   // Round-robin pointers (index of the VC with highest priority)
   logic [REQ_W-1:0]    alloc_ptr_q, alloc_ptr_d;
   logic [REQ_W-1:0]    rel_ptr_q, rel_ptr_d;

   // Registered outputs
   logic [NUM_REQ-1:0]  alloc_gnt_q, alloc_gnt_d;
   logic [SLOT_W-1:0]   alloc_slot_q, alloc_slot_d;
   logic                none_free_q, none_free_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_udf_q, err_udf_d;

   // Arbitration
   logic [NUM_REQ-1:0]  vc_empty;
   logic [NUM_REQ-1:0]  alloc_elig;
   logic [NUM_REQ-1:0]  rel_legal;
   logic [NUM_REQ-1:0]  vc_inc;
   logic [NUM_REQ-1:0]  vc_dec;
   logic                alloc_found, rel_found;
   logic [REQ_W-1:0]    alloc_win, rel_win;
   logic                pop, push, list_full;
   logic [SLOT_W-1:0]   push_slot;

   // (base + off) modulo NUM_REQ, used to walk requesters in RR order
   function automatic logic [REQ_W-1:0] rr_index(input logic [REQ_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned sum;
      sum = 32'(base) + off;
      return REQ_W'(sum % NUM_REQ);
   endfunction

   // Free-list pointer increment with wrap at NUM_SLOTS
   function automatic logic [SLOT_W-1:0] wrap_inc(input logic [SLOT_W-1:0] p);
      return (p == SLOT_W'(NUM_SLOTS - 1)) ? '0 : p + SLOT_W'(1);
   endfunction

   // Per-VC status: empty (release illegal) and below cap (allocation legal)
   always_comb begin
      vc_empty   = '0;
      alloc_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         vc_empty[i]   = (vc_cnt_q[i] == '0);
         alloc_elig[i] = alloc_req_i[i] && (vc_cnt_q[i] < VC_CNT_W'(MAX_PER_REQ));
      end
   end

   // Allocation arbiter: first eligible VC starting at the RR pointer
   always_comb begin
      alloc_found = 1'b0;
      alloc_win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!alloc_found && alloc_elig[rr_index(alloc_ptr_q, k)]) begin
            alloc_found = 1'b1;
            alloc_win   = rr_index(alloc_ptr_q, k);
         end
      end
   end

   // A pop only happens when the list holds a slot; a release in this same
   // cycle is pushed at the tail and is never visible to this pop.
   assign pop       = alloc_found && (free_count_q != '0);
   assign list_full = (free_count_q == CNT_W'(NUM_SLOTS));

   // Illegal releases are masked out before arbitration so they never block
   // a legal requester further round the ring.
   assign rel_legal = free_req_i & ~vc_empty & {NUM_REQ{!(list_full && !pop)}};

   // Release arbiter: first legal VC starting at its own RR pointer
   always_comb begin
      rel_found = 1'b0;
      rel_win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!rel_found && rel_legal[rr_index(rel_ptr_q, k)]) begin
            rel_found = 1'b1;
            rel_win   = rr_index(rel_ptr_q, k);
         end
      end
   end

   assign push       = rel_found;
   assign push_slot  = free_slot_i[rel_win*SLOT_W +: SLOT_W];
   assign free_ack_o = push ? (NUM_REQ'(1) << rel_win) : '0;

   // Per-VC increment/decrement strobes for this cycle
   always_comb begin
      vc_inc = '0;
      vc_dec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         vc_inc[i] = pop  && (alloc_win == REQ_W'(i));
         vc_dec[i] = push && (rel_win == REQ_W'(i));
      end
   end

   // Next-state for pointers, counters, registered outputs and error flags
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      free_count_d = free_count_q;
      alloc_ptr_d  = alloc_ptr_q;
      rel_ptr_d    = rel_ptr_q;
      alloc_gnt_d  = '0;
      alloc_slot_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         vc_cnt_d[i] = vc_cnt_q[i];
      end

      if (pop) begin
         head_d       = wrap_inc(head_q);
         alloc_gnt_d  = NUM_REQ'(1) << alloc_win;
         alloc_slot_d = fifo_q[head_q];
         alloc_ptr_d  = rr_index(alloc_win, 1);
      end

      if (push) begin
         tail_d    = wrap_inc(tail_q);
         rel_ptr_d = rr_index(rel_win, 1);
      end

      case ({pop, push})
         2'b10:   free_count_d = free_count_q - CNT_W'(1);
         2'b01:   free_count_d = free_count_q + CNT_W'(1);
         default: free_count_d = free_count_q;
      endcase

      for (int i = 0; i < NUM_REQ; i++) begin
         if (vc_inc[i] && !vc_dec[i]) begin
            vc_cnt_d[i] = vc_cnt_q[i] + VC_CNT_W'(1);
         end else if (vc_dec[i] && !vc_inc[i]) begin
            vc_cnt_d[i] = vc_cnt_q[i] - VC_CNT_W'(1);
         end
      end

      none_free_d = (free_count_d == '0);
      err_udf_d   = err_udf_q | (|(free_req_i & vc_empty));
      err_ovf_d   = err_ovf_q | (list_full && !pop && (|(free_req_i & ~vc_empty)));
   end

   // Free-list storage: reset to 0..NUM_SLOTS-1, written at the tail on push
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            fifo_q[i] <= SLOT_W'(i);
         end
      end else if (push) begin
         fifo_q[tail_q] <= push_slot;
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q       <= '0;
         tail_q       <= '0;
         free_count_q <= CNT_W'(NUM_SLOTS);
         alloc_ptr_q  <= '0;
         rel_ptr_q    <= '0;
         alloc_gnt_q  <= '0;
         alloc_slot_q <= '0;
         none_free_q  <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_udf_q    <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            vc_cnt_q[i] <= '0;
         end
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         free_count_q <= free_count_d;
         alloc_ptr_q  <= alloc_ptr_d;
         rel_ptr_q    <= rel_ptr_d;
         alloc_gnt_q  <= alloc_gnt_d;
         alloc_slot_q <= alloc_slot_d;
         none_free_q  <= none_free_d;
         err_ovf_q    <= err_ovf_d;
         err_udf_q    <= err_udf_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            vc_cnt_q[i] <= vc_cnt_d[i];
         end
      end
   end

   // Flatten per-VC counts onto the output bus
   always_comb begin
      vc_count_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         vc_count_o[i*VC_CNT_W +: VC_CNT_W] = vc_cnt_q[i];
      end
   end

   assign alloc_gnt_o     = alloc_gnt_q;
   assign alloc_slot_o    = alloc_slot_q;
   assign free_count_o    = free_count_q;
   assign none_free_o     = none_free_q;
   assign err_overflow_o  = err_ovf_q;
   assign err_underflow_o = err_udf_q;

endmodule

// File: tb/tb_shared_buffer_alloc_ctrl.sv
// Bench for shared_buffer_alloc_ctrl: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a queue-based model.
module tb_shared_buffer_alloc_ctrl;

   localparam int NUM_REQ     = 4;
   localparam int NUM_SLOTS   = 32;
   localparam int MAX_PER_REQ = 16;
   localparam int SLOT_W      = 5;
   localparam int CNT_W       = 6;
   localparam int VC_CNT_W    = 5;

   // ---------------- clock / reset / DUT ----------------
   logic                        clk;
   logic                        reset;
   logic [NUM_REQ-1:0]          alloc_req;
   logic [NUM_REQ-1:0]          alloc_gnt;
   logic [SLOT_W-1:0]           alloc_slot;
   logic [NUM_REQ-1:0]          free_req;
   logic [NUM_REQ*SLOT_W-1:0]   free_slot;
   logic [NUM_REQ-1:0]          free_ack;
   logic [CNT_W-1:0]            free_count;
   logic [NUM_REQ*VC_CNT_W-1:0] vc_count;
   logic                        none_free;
   logic                        err_overflow;
   logic                        err_underflow;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   shared_buffer_alloc_ctrl #(
      .NUM_REQ     (NUM_REQ),
      .NUM_SLOTS   (NUM_SLOTS),
      .MAX_PER_REQ (MAX_PER_REQ)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .alloc_req_i     (alloc_req),
      .alloc_gnt_o     (alloc_gnt),
      .alloc_slot_o    (alloc_slot),
      .free_req_i      (free_req),
      .free_slot_i     (free_slot),
      .free_ack_o      (free_ack),
      .free_count_o    (free_count),
      .vc_count_o      (vc_count),
      .none_free_o     (none_free),
      .err_overflow_o  (err_overflow),
      .err_underflow_o (err_underflow)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec;
   int n_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] vcs(input int c3, input int c2, input int c1, input int c0);
      return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
   endfunction

   // ---------------- driver tasks ----------------
   // Inputs change just after the rising edge; free_ack is sampled at the
   // falling edge, registered outputs 1 time unit after the next rising edge.
   task automatic drive_cycle(input logic rst, input logic [3:0] areq, input logic [3:0] freq,
                              input logic [19:0] fs, input logic [3:0] exp_ack, input string tag);
      reset     = rst;
      alloc_req = areq;
      free_req  = freq;
      free_slot = fs;
      @(negedge clk);
      if (!rst) check({tag, ".free_ack"}, 32'(free_ack), 32'(exp_ack));
      @(posedge clk);
      #1;
   endtask

   task automatic expect_regs(input string tag, input logic [3:0] gnt, input logic [4:0] slot,
                              input bit chk_slot, input int fc, input logic [19:0] vc,
                              input logic nf, input logic eu, input logic eo);
      check({tag, ".alloc_gnt"}, 32'(alloc_gnt), 32'(gnt));
      if (chk_slot) check({tag, ".alloc_slot"}, 32'(alloc_slot), 32'(slot));
      check({tag, ".free_count"}, 32'(free_count), 32'(fc));
      check({tag, ".vc_count"}, 32'(vc_count), 32'(vc));
      check({tag, ".none_free"}, 32'(none_free), 32'(nf));
      check({tag, ".err_underflow"}, 32'(err_underflow), 32'(eu));
      check({tag, ".err_overflow"}, 32'(err_overflow), 32'(eo));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic [3:0]  areq;
      logic [3:0]  freq;
      logic [19:0] fs;
      logic [3:0]  ack;
      logic [3:0]  gnt;
      logic [4:0]  slot;
      int          fc;
      logic [19:0] vc;
      logic        nf;
      logic        eu;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] areq, input logic [3:0] freq,
                               input logic [19:0] fs, input logic [3:0] ack, input logic [3:0] gnt,
                               input logic [4:0] slot, input int fc, input logic [19:0] vc,
                               input logic nf, input logic eu);
      vec_t v;
      v.rst = rst; v.areq = areq; v.freq = freq; v.fs = fs; v.ack = ack;
      v.gnt = gnt; v.slot = slot; v.fc = fc; v.vc = vc; v.nf = nf; v.eu = eu;
      return v;
   endfunction

   // ---------------- behavioural reference model ----------------
   // Free list as a plain queue, per-VC holdings as lists of slot numbers.
   int               m_free[$];
   int               m_held[NUM_REQ][$];
   int               m_aptr;
   int               m_rptr;
   bit               m_eu;
   bit               m_eo;
   logic [3:0]       m_gnt;
   logic [SLOT_W-1:0] exp_q[$];

   task automatic model_reset();
      m_free.delete();
      for (int i = 0; i < NUM_SLOTS; i++) m_free.push_back(i);
      for (int i = 0; i < NUM_REQ; i++) m_held[i].delete();
      m_aptr = 0;
      m_rptr = 0;
      m_eu   = 1'b0;
      m_eo   = 1'b0;
      m_gnt  = '0;
      exp_q.delete();
   endtask

   task automatic random_cycle(input int cyc);
      logic        rst;
      logic [3:0]  areq, freq, ack;
      logic [19:0] fs;
      int          pick[NUM_REQ];
      bit          pop, rel, full;
      int          aw, rw, idx, s, sum;
      logic [SLOT_W-1:0] got;
      rst  = ($urandom_range(0, 299) == 0);
      areq = 4'($urandom_range(0, 15));
      freq = 4'($urandom_range(0, 15));
      fs   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (m_held[i].size() > 0) begin
            pick[i] = $urandom_range(0, m_held[i].size() - 1);
            fs[i*SLOT_W +: SLOT_W] = 5'(m_held[i][pick[i]]);
         end else begin
            pick[i] = -1;
            fs[i*SLOT_W +: SLOT_W] = 5'($urandom_range(0, NUM_SLOTS - 1));
         end
      end

      // Rules: allocate to the first requesting VC under its cap, searching
      // from the RR pointer, if any slot is free. Release the first requesting
      // VC that holds a slot, unless the list is full with nothing popped.
      pop = 1'b0; aw = 0;
      if (m_free.size() > 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_aptr + k) % NUM_REQ;
            if (!pop && areq[idx] && m_held[idx].size() < MAX_PER_REQ) begin
               pop = 1'b1; aw = idx;
            end
         end
      end
      full = (m_free.size() == NUM_SLOTS);
      rel = 1'b0; rw = 0; ack = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (m_rptr + k) % NUM_REQ;
         if (!rel && freq[idx] && m_held[idx].size() > 0 && !(full && !pop)) begin
            rel = 1'b1; rw = idx; ack[idx] = 1'b1;
         end
      end

      drive_cycle(rst, areq, freq, fs, ack, $sformatf("rnd%0d", cyc));

      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (freq[i] && m_held[i].size() == 0) m_eu = 1'b1;
            if (freq[i] && m_held[i].size() > 0 && full && !pop) m_eo = 1'b1;
         end
         m_gnt = '0;
         if (pop) begin
            s = m_free.pop_front();
            m_held[aw].push_back(s);
            exp_q.push_back(5'(s));
            m_gnt[aw] = 1'b1;
            m_aptr = (aw + 1) % NUM_REQ;
         end
         if (rel) begin
            m_free.push_back(int'(fs[rw*SLOT_W +: SLOT_W]));
            m_held[rw].delete(pick[rw]);
            m_rptr = (rw + 1) % NUM_REQ;
         end
      end

      check($sformatf("rnd%0d.alloc_gnt", cyc), 32'(alloc_gnt), 32'(m_gnt));
      if (alloc_gnt != '0) begin
         if (exp_q.size() == 0) begin
            check($sformatf("rnd%0d.unexpected_grant", cyc), 32'(alloc_gnt), 32'(0));
         end else begin
            got = exp_q.pop_front();
            check($sformatf("rnd%0d.alloc_slot", cyc), 32'(alloc_slot), 32'(got));
         end
      end
      check($sformatf("rnd%0d.free_count", cyc), 32'(free_count), 32'(m_free.size()));
      check($sformatf("rnd%0d.vc_count", cyc), 32'(vc_count),
            32'(vcs(m_held[3].size(), m_held[2].size(), m_held[1].size(), m_held[0].size())));
      check($sformatf("rnd%0d.none_free", cyc), 32'(none_free), 32'(m_free.size() == 0));
      check($sformatf("rnd%0d.err_underflow", cyc), 32'(err_underflow), 32'(m_eu));
      check($sformatf("rnd%0d.err_overflow", cyc), 32'(err_overflow), 32'(m_eo));
      sum = int'(free_count);
      for (int i = 0; i < NUM_REQ; i++) sum += int'(vc_count[i*VC_CNT_W +: VC_CNT_W]);
      check($sformatf("rnd%0d.slot_total", cyc), 32'(sum), 32'(NUM_SLOTS));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [19:0] fs_a;
      logic [19:0] fs_b;
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      alloc_req = '0;
      free_req  = '0;
      free_slot = '0;
      @(posedge clk);
      #1;

      // VC0 returns slot 4, VC2 returns slot 2
      fs_a = {5'd0, 5'd2, 5'd0, 5'd4};

      //            rst  areq     freq     fs    ack      gnt      slot  fc  vc               nf  eu
      tbl.push_back(mk(1, 4'b0000, 4'b0000, '0,   4'b0000, 4'b0000, 5'd0, 32, vcs(0,0,0,0), 0, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, '0,   4'b0000, 4'b0001, 5'd0, 31, vcs(0,0,0,1), 0, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, '0,   4'b0000, 4'b0001, 5'd1, 30, vcs(0,0,0,2), 0, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, '0,   4'b0000, 4'b0001, 5'd2, 29, vcs(0,0,0,3), 0, 0));
      tbl.push_back(mk(1, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0000, 5'd0, 32, vcs(0,0,0,0), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0001, 5'd0, 31, vcs(0,0,0,1), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0010, 5'd1, 30, vcs(0,0,1,1), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0100, 5'd2, 29, vcs(0,1,1,1), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b1000, 5'd3, 28, vcs(1,1,1,1), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0001, 5'd4, 27, vcs(1,1,1,2), 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, '0,   4'b0000, 4'b0010, 5'd5, 26, vcs(1,1,2,2), 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0101, fs_a, 4'b0001, 4'b0000, 5'd0, 27, vcs(1,1,2,1), 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0101, fs_a, 4'b0100, 4'b0000, 5'd0, 28, vcs(1,0,2,1), 0, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0100, fs_a, 4'b0000, 4'b0000, 5'd0, 28, vcs(1,0,2,1), 0, 1));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, '0,   4'b0000, 4'b0001, 5'd6, 27, vcs(1,0,2,2), 0, 1));
      tbl.push_back(mk(1, 4'b0000, 4'b0000, '0,   4'b0000, 4'b0000, 5'd0, 32, vcs(0,0,0,0), 0, 0));

      foreach (tbl[r]) begin
         drive_cycle(tbl[r].rst, tbl[r].areq, tbl[r].freq, tbl[r].fs, tbl[r].ack,
                     $sformatf("vec%0d", r));
         expect_regs($sformatf("vec%0d", r), tbl[r].gnt, tbl[r].slot,
                     (tbl[r].gnt != '0) || tbl[r].rst, tbl[r].fc, tbl[r].vc,
                     tbl[r].nf, tbl[r].eu, 1'b0);
      end

      // VC0 alone fills up to its cap of 16
      for (int k = 0; k < 16; k++) begin
         drive_cycle(1'b0, 4'b0001, 4'b0000, '0, 4'b0000, $sformatf("cap_a%0d", k));
         expect_regs($sformatf("cap_a%0d", k), 4'b0001, 5'(k), 1'b1, 31 - k,
                     vcs(0, 0, 0, k + 1), 1'b0, 1'b0, 1'b0);
      end
      // VC0 capped: every further grant goes to VC1 until the bank is empty
      for (int k = 0; k < 16; k++) begin
         drive_cycle(1'b0, 4'b0011, 4'b0000, '0, 4'b0000, $sformatf("cap_b%0d", k));
         expect_regs($sformatf("cap_b%0d", k), 4'b0010, 5'(16 + k), 1'b1, 15 - k,
                     vcs(0, 0, k + 1, 16), (k == 15), 1'b0, 1'b0);
      end
      // Bank exhausted: no grant
      drive_cycle(1'b0, 4'b0011, 4'b0000, '0, 4'b0000, "empty");
      expect_regs("empty", 4'b0000, 5'd0, 1'b0, 0, vcs(0, 0, 16, 16), 1'b1, 1'b0, 1'b0);
      // VC1 returns slot 7: acked the same cycle, no grant from that cycle
      fs_b = {5'd0, 5'd0, 5'd7, 5'd0};
      drive_cycle(1'b0, 4'b0011, 4'b0010, fs_b, 4'b0010, "ret7");
      expect_regs("ret7", 4'b0000, 5'd0, 1'b0, 1, vcs(0, 0, 15, 16), 1'b0, 1'b0, 1'b0);
      // Slot 7 granted to VC1 two cycles after its release
      drive_cycle(1'b0, 4'b0011, 4'b0000, '0, 4'b0000, "regrant7");
      expect_regs("regrant7", 4'b0010, 5'd7, 1'b1, 0, vcs(0, 0, 16, 16), 1'b1, 1'b0, 1'b0);
      // Reset in the middle of traffic
      drive_cycle(1'b1, 4'b1111, 4'b1111, fs_b, 4'b0000, "midrst");
      expect_regs("midrst", 4'b0000, 5'd0, 1'b1, 32, vcs(0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 4'b1111, 4'b0000, '0, 4'b0000, "postrst");
      expect_regs("postrst", 4'b0001, 5'd0, 1'b1, 31, vcs(0, 0, 0, 1), 1'b0, 1'b0, 1'b0);
      // VC1 (empty) refused, VC0 still released in the same cycle
      drive_cycle(1'b0, 4'b0000, 4'b0011, '0, 4'b0001, "mixrel");
      expect_regs("mixrel", 4'b0000, 5'd0, 1'b0, 32, vcs(0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

      // Randomized run against the model
      drive_cycle(1'b1, 4'b0000, 4'b0000, '0, 4'b0000, "rndrst");
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         random_cycle(c);
      end
      drive_cycle(1'b0, 4'b0000, 4'b0000, '0, 4'b0000, "drain");
      check("drain.alloc_gnt", 32'(alloc_gnt), 32'(0));
      check("exp_q_empty", 32'(exp_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
